// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage BRISC pipeline.
// Drives per-stage enables/flushes for hazards, misses and multiplies.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic ld_use_hz,
  input  logic br_taken_ex,
  input  logic mul_in_ex,
  input  logic icache_miss,
  input  logic icache_fill_done,
  input  logic dcache_miss,
  input  logic dcache_fill_done,
  output logic pc_en,
  output logic en_fd,
  output logic en_de,
  output logic en_em,
  output logic en_mw,
  output logic flush_fd,
  output logic flush_de,
  output logic flush_em,
  output logic flush_mw,
  output logic icache_abort
);

  localparam int CW = $clog2(MUL_LAT);
  localparam logic [CW-1:0] MCNT_INIT = CW'(MUL_LAT - 3);

  typedef enum logic [1:0] {
    RUN,
    I_WAIT,
    D_WAIT,
    MUL_BUSY
  } state_t;

  // {pc, en fd/de/em/mw, flush fd/de/em/mw, abort}
  typedef struct packed {
    logic       pc;
    logic [3:0] en;
    logic [3:0] fl;
    logic       abort;
  } ctl_t;

  localparam ctl_t P_IDLE = 10'b1_1111_0000_0;
  localparam ctl_t P_RST  = 10'b0_0000_1111_0;
  localparam ctl_t P_DST  = 10'b0_0001_0001_0;
  localparam ctl_t P_MST  = 10'b0_0011_0010_0;
  localparam ctl_t P_IST  = 10'b0_1111_1000_0;
  localparam ctl_t P_RED  = 10'b1_1111_1100_0;
  localparam ctl_t P_LU   = 10'b0_0111_0100_0;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   mcnt_q;
  logic [CW-1:0]   mcnt_d;
  logic            mul_done_q;
  logic            mul_done_d;
  ctl_t            ctl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      mcnt_q     <= '0;
      mul_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcnt_q     <= mcnt_d;
      mul_done_q <= mul_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mcnt_d     = mcnt_q;
    mul_done_d = mul_done_q;
    ctl        = P_IDLE;
    if (reset) begin
      ctl = P_RST;
    end else begin
      unique case (state_q)
        RUN: begin
          mul_done_d = 1'b0;
          if (dcache_miss) begin
            ctl     = P_DST;
            state_d = D_WAIT;
          end else if (mul_in_ex && !mul_done_q) begin
            ctl     = P_MST;
            mcnt_d  = MCNT_INIT;
            state_d = MUL_BUSY;
          end else if (br_taken_ex) begin
            ctl       = P_RED;
            ctl.abort = icache_miss;
          end else if (icache_miss) begin
            ctl     = ld_use_hz ? P_LU : P_IST;
            state_d = I_WAIT;
          end else if (ld_use_hz) begin
            ctl = P_LU;
          end
        end
        I_WAIT: begin
          if (dcache_miss) begin
            ctl     = P_DST;
            state_d = D_WAIT;
          end else if (br_taken_ex) begin
            ctl       = P_RED;
            ctl.abort = 1'b1;
            state_d   = RUN;
          end else begin
            ctl = ld_use_hz ? P_LU : P_IST;
            if (icache_fill_done) state_d = RUN;
          end
        end
        D_WAIT: begin
          ctl = P_DST;
          if (dcache_fill_done) state_d = RUN;
        end
        MUL_BUSY: begin
          ctl = P_MST;
          if (mcnt_q == '0) begin
            state_d    = RUN;
            mul_done_d = 1'b1;
          end else begin
            mcnt_d = mcnt_q - CW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_en        = ctl.pc;
  assign en_fd        = ctl.en[3];
  assign en_de        = ctl.en[2];
  assign en_em        = ctl.en[1];
  assign en_mw        = ctl.en[0];
  assign flush_fd     = ctl.fl[3];
  assign flush_de     = ctl.fl[2];
  assign flush_em     = ctl.fl[1];
  assign flush_mw     = ctl.fl[0];
  assign icache_abort = ctl.abort;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, MUL stall count,
// then random inputs against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 5;

  // {pc, en fd/de/em/mw, flush fd/de/em/mw, abort}
  localparam logic [9:0] IDLE = 10'b1_1111_0000_0;
  localparam logic [9:0] RST  = 10'b0_0000_1111_0;
  localparam logic [9:0] DST  = 10'b0_0001_0001_0;
  localparam logic [9:0] MST  = 10'b0_0011_0010_0;
  localparam logic [9:0] IST  = 10'b0_1111_1000_0;
  localparam logic [9:0] RED  = 10'b1_1111_1100_0;
  localparam logic [9:0] REDA = 10'b1_1111_1100_1;
  localparam logic [9:0] LU   = 10'b0_0111_0100_0;

  logic clk = 1'b0;
  logic reset, ld_use_hz, br_taken_ex, mul_in_ex;
  logic icache_miss, icache_fill_done, dcache_miss, dcache_fill_done;
  logic pc_en, en_fd, en_de, en_em, en_mw;
  logic flush_fd, flush_de, flush_em, flush_mw, icache_abort;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .ld_use_hz(ld_use_hz), .br_taken_ex(br_taken_ex),
    .mul_in_ex(mul_in_ex), .icache_miss(icache_miss),
    .icache_fill_done(icache_fill_done), .dcache_miss(dcache_miss),
    .dcache_fill_done(dcache_fill_done),
    .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_em(en_em),
    .en_mw(en_mw), .flush_fd(flush_fd), .flush_de(flush_de),
    .flush_em(flush_em), .flush_mw(flush_mw),
    .icache_abort(icache_abort)
  );

  // inputs: {reset, ld, br, mul, imiss, ifill, dmiss, dfill}
  typedef struct {
    string      name;
    logic [7:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nvec  = 0;
  int   nfail = 0;

  // behavioural model: what the pipeline is currently waiting on
  bit m_dwait, m_iwait, m_mdone;
  int m_mleft;

  task automatic add(input string n, input logic [7:0] i,
                     input logic [9:0] e, input int rep = 1);
    vec_t v;
    v.name = n; v.in = i; v.exp = e;
    for (int k = 0; k < rep; k++) tbl.push_back(v);
  endtask

  task automatic model_step(input logic [7:0] in, output logic [9:0] e);
    logic r, ld, br, mul, im, ifd, dm, dfd;
    bit   md;
    {r, ld, br, mul, im, ifd, dm, dfd} = in;
    e = IDLE;
    if (r) begin
      e = RST;
      m_dwait = 0; m_iwait = 0; m_mdone = 0; m_mleft = 0;
    end else if (m_dwait) begin
      e = DST;
      if (dfd) m_dwait = 0;
    end else if (m_mleft > 0) begin
      e = MST;
      m_mleft--;
      if (m_mleft == 0) m_mdone = 1;
    end else if (m_iwait) begin
      if (dm) begin
        e = DST; m_dwait = 1; m_iwait = 0;
      end else if (br) begin
        e = REDA; m_iwait = 0;
      end else begin
        e = ld ? LU : IST;
        if (ifd) m_iwait = 0;
      end
    end else begin
      md = m_mdone;
      m_mdone = 0;
      if (dm) begin
        e = DST; m_dwait = 1;
      end else if (mul && !md) begin
        e = MST; m_mleft = MUL_LAT - 2;
      end else if (br) begin
        e = im ? REDA : RED;
      end else if (im) begin
        e = ld ? LU : IST; m_iwait = 1;
      end else if (ld) begin
        e = LU;
      end
    end
  endtask

  task automatic apply(input logic [7:0] in, output logic [9:0] got,
                       output logic [9:0] mexp);
    {reset, ld_use_hz, br_taken_ex, mul_in_ex,
     icache_miss, icache_fill_done, dcache_miss, dcache_fill_done} = in;
    @(negedge clk);
    got = {pc_en, en_fd, en_de, en_em, en_mw,
           flush_fd, flush_de, flush_em, flush_mw, icache_abort};
    model_step(in, mexp);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input int idx,
                       input logic [9:0] got, input logic [9:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s #%0d: got %b expected %b", n, idx, got, exp);
    end
  endtask

  initial begin
    logic [9:0] got, mexp;
    logic [7:0] in;
    int         lowcnt;

    add("rst", 8'b1000_0000, RST, 2);
    add("idle", 8'b0000_0000, IDLE);
    add("mul", 8'b0001_0000, MST, 4);
    add("mul_done", 8'b0001_0000, IDLE);
    add("idle", 8'b0000_0000, IDLE);
    add("dmiss_br", 8'b0010_0010, DST, 5);
    add("dfill_br", 8'b0010_0011, DST);
    add("redirect", 8'b0010_0000, RED);
    add("idle", 8'b0000_0000, IDLE);
    add("imiss", 8'b0000_1000, IST, 2);
    add("imiss_br", 8'b0010_1000, REDA);
    add("idle_run", 8'b0000_0000, IDLE);
    add("imiss_lu", 8'b0100_1000, LU);
    add("ifill", 8'b0000_1100, IST);
    add("idle", 8'b0000_0000, IDLE);
    add("ld_use", 8'b0100_0000, LU);
    add("br_imiss_run", 8'b0010_1000, REDA);
    add("idle", 8'b0000_0000, IDLE);
    add("mul_pre_rst", 8'b0001_0000, MST, 2);
    add("rst_mid_mul", 8'b1001_0000, RST);
    add("mul_restart", 8'b0001_0000, MST, 4);
    add("mul_done2", 8'b0001_0000, IDLE);
    add("idle", 8'b0000_0000, IDLE);
    add("dmiss_all", 8'b0111_1010, DST);
    add("dwait_ignore", 8'b0111_1010, DST);
    add("dwait_fill", 8'b0000_1011, DST);
    add("i_reenter", 8'b0000_1000, IST);
    add("iwait_dmiss", 8'b0010_1010, DST);
    add("dfill2", 8'b0000_1011, DST);
    add("imiss3", 8'b0000_1000, IST);
    add("ifill3", 8'b0000_1100, IST);
    add("idle", 8'b0000_0000, IDLE);
    add("mul_im", 8'b0001_0000, MST);
    add("busy_im", 8'b0001_1000, MST, 3);
    add("mdone_im", 8'b0001_1000, IST);
    add("ifill4", 8'b0000_1100, IST);
    add("idle", 8'b0000_0000, IDLE);
    add("imiss5", 8'b0000_1000, IST);
    add("iwait_lu", 8'b0100_1000, LU);
    add("iwait_fill_lu", 8'b0100_1100, LU);
    add("idle", 8'b0000_0000, IDLE);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].in, got, mexp);
      check(tbl[i].name, i, got, tbl[i].exp);
    end

    // full MUL held in E: en_de low for MUL_LAT-1 cycles
    lowcnt = 0;
    for (int i = 0; i < MUL_LAT; i++) begin
      apply(8'b0001_0000, got, mexp);
      if (got[7] == 1'b0) lowcnt++;
    end
    nvec++;
    if (lowcnt != MUL_LAT - 1) begin
      nfail++;
      $display("FAIL mul_stall_len: got %0d expected %0d",
               lowcnt, MUL_LAT - 1);
    end
    check("mul_exit", 0, got, IDLE);
    apply(8'b0000_0000, got, mexp);
    check("post_mul", 0, got, IDLE);

    for (int i = 0; i < 4000; i++) begin
      in[7] = ($urandom_range(0, 63) == 0);
      in[6] = ($urandom_range(0, 5) == 0);
      in[5] = ($urandom_range(0, 7) == 0);
      in[4] = ($urandom_range(0, 3) == 0);
      in[3] = ($urandom_range(0, 3) == 0);
      in[2] = ($urandom_range(0, 5) == 0);
      in[1] = ($urandom_range(0, 11) == 0);
      in[0] = ($urandom_range(0, 3) == 0);
      apply(in, got, mexp);
      check("rand", i, got, mexp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline stall/flush controller for the 5-stage BRISC core (F, D, E, M, W). It is the driving end of the pipeline-register control interface: it generates the per-stage `enable` and synchronous `reset` (flush) signals consumed by the `ff`/`nff` stage registers. It arbitrates load-use hazards, taken branches, I-cache and D-cache misses, and multi-cycle multiplies. Internally it is a 4-state FSM with a multiply latency counter.

## Interface

Parameters:
- `MUL_LAT`, default 5: total cycles a MUL instruction occupies E. Legal values are MUL_LAT >= 3.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `ld_use_hz`  in  1: load in E whose rd matches a source of the instruction in D.
- `br_taken_ex`  in  1: branch/jump resolved taken in E. Level; held while E is frozen.
- `mul_in_ex`  in  1: a MUL occupies E. Level.
- `icache_miss`  in  1: fetch not ready. Level; held up to and including the `icache_fill_done` cycle.
- `icache_fill_done`  in  1: single-cycle pulse.
- `dcache_miss`  in  1: load/store in M missed. Level; held up to and including the `dcache_fill_done` cycle.
- `dcache_fill_done`  in  1: single-cycle pulse.
- `pc_en`  out  1: PC register enable.
- `en_fd`, `en_de`, `en_em`, `en_mw`  out  1 each: stage register enables.
- `flush_fd`, `flush_de`, `flush_em`, `flush_mw`  out  1 each: stage register synchronous resets; a flush inserts a bubble.
- `icache_abort`  out  1: single-cycle pulse; cancels the outstanding I-fill on redirect.

## Operation

- State register: RUN, I_WAIT, D_WAIT, MUL_BUSY.
- Sequential state: 2-bit state, a `$clog2(MUL_LAT)`-bit counter `mcnt`, and a 1-bit `mul_done` flag.
- Outputs are combinational from state and inputs.
- Output patterns:
  - Idle: all `en_*` = 1, `pc_en` = 1, all `flush_*` = 0, `icache_abort` = 0.
  - D-stall: `pc_en` = `en_fd` = `en_de` = `en_em` = 0, `flush_mw` = 1.
  - M-stall: `pc_en` = `en_fd` = `en_de` = 0, `flush_em` = 1, `en_mw` = 1.
  - I-stall: `pc_en` = 0, `flush_fd` = 1, all other enables = 1.
  - Redirect: `pc_en` = 1, `flush_fd` = `flush_de` = 1, other enables = 1.
  - Load-use: `pc_en` = 0, `en_fd` = 0, `flush_fd` = 0, `flush_de` = 1.
- RUN, evaluated in priority order:
  1. `dcache_miss` → D-stall; next state D_WAIT.
  2. `mul_in_ex & !mul_done` → M-stall; load `mcnt = MUL_LAT-3`; next state MUL_BUSY.
  3. `br_taken_ex` → Redirect. Also assert `icache_abort` if `icache_miss`. Stay in RUN.
  4. `icache_miss` → I-stall, with the load-use override below. Next state I_WAIT.
  5. `ld_use_hz` → Load-use.
  6. Otherwise → Idle.
- In RUN, if `mul_done` = 1: Idle pattern (the MUL leaves E) and clear `mul_done`. Any lower-priority item from the list above still applies.
- Load-use override: whenever I-stall is active and `ld_use_hz` = 1, force `en_fd` = 0, `flush_fd` = 0, `flush_de` = 1.
- D_WAIT: D-stall every cycle, including the `dcache_fill_done` cycle. On fill_done, next state is RUN. All other inputs are ignored.
- MUL_BUSY: M-stall. If `mcnt` = 0, next state RUN and set `mul_done` = 1; otherwise decrement `mcnt`. `icache_miss` is ignored (F is frozen); `dcache_miss` cannot occur (M holds bubbles).
- I_WAIT, evaluated in priority order:
  1. `dcache_miss` → D-stall; next state D_WAIT. `icache_miss` is still high on return, so RUN re-enters I_WAIT.
  2. `br_taken_ex` → Redirect plus `icache_abort`; next state RUN.
  3. Otherwise → I-stall with the load-use override. On `icache_fill_done`, next state RUN (the fill cycle is still stalled).
- Reset has priority over everything:
  - State RUN, `mcnt` = 0, `mul_done` = 0.
  - While `reset` = 1: all `flush_*` = 1, all `en_*` = 0, `pc_en` = 0, `icache_abort` = 0.
  - Reset mid-miss or mid-MUL discards all progress; the first cycle after reset deasserts is evaluated as RUN.

## Timing

- Load-use bubble: exactly 1 cycle per assertion of `ld_use_hz`; the hazard unit deasserts it once the load reaches M.
- Taken branch: 2 bubbles (FD and DE flushed in the same cycle). The PC loads the target on that edge.
- D-miss: stall spans from the first `dcache_miss` cycle through the fill_done cycle. M advances on the edge after fill_done.
- MUL: exactly MUL_LAT cycles in E, i.e. MUL_LAT-1 stall cycles: 1 entry cycle + (MUL_LAT-2) MUL_BUSY cycles, then one RUN cycle with `mul_done`.
- I-miss: one bubble per stalled cycle enters D. Fetch resumes on the edge after fill_done.
- `icache_abort` is high for exactly 1 cycle per redirect that hits an outstanding miss.

## Test plan

- Reset for 2 cycles, then idle inputs → during reset `flush_*` = 4'b1111, `en_*` = 0. Cycle after: Idle pattern, state RUN.
- `mul_in_ex` held high, MUL_LAT = 5 → M-stall for exactly 4 cycles, then 1 Idle cycle; `en_de` low 4 cycles total.
- `dcache_miss` high 6 cycles with fill_done in cycle 6, plus `br_taken_ex` high throughout → D-stall for 6 cycles, then Redirect in cycle 7.
- `icache_miss` asserted, `br_taken_ex` rises 2 cycles later → `icache_abort` = 1 for 1 cycle, `flush_fd` = `flush_de` = 1, state back to RUN.
- `icache_miss` together with `ld_use_hz` for 1 cycle → `en_fd` = 0, `flush_fd` = 0, `flush_de` = 1, `pc_en` = 0.
- `reset` asserted in the 2nd MUL_BUSY cycle → next cycle state RUN, `mul_done` = 0. With `mul_in_ex` still high after reset, a full MUL_LAT-1-cycle stall restarts.
